// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequences the fetch PC against a combinational
// instruction memory and buffers {pc, instr} pairs in a small FIFO for decode.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [5:0]               imem_addr,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W        = $clog2(DEPTH);
   localparam int unsigned CNT_W        = PTR_W + 1;
   localparam logic [31:0] RESET_PC_ALN = RESET_PC & ~32'h3;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t            slot_q [DEPTH];
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push;
   logic              pop;

   // Handshake qualifiers; redirect suppresses both push and the visible head.
   always_comb begin
      out_valid = (count_q != '0) && !redirect;
      push      = !redirect && (count_q != CNT_W'(DEPTH));
      pop       = out_valid && out_ready;
   end

   // Next-state for pointers, occupancy and fetch PC.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc & ~32'h3;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            tail_d     = tail_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC_ALN;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Storage captures imem_rdata on the same edge that advances fetch_pc.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            slot_q[i] <= '0;
         end
      end else if (push) begin
         slot_q[tail_q] <= {fetch_pc_q, imem_rdata};
      end
   end

   assign imem_addr = fetch_pc_q[7:2];
   assign out_instr = slot_q[head_q].instr;
   assign out_pc    = slot_q[head_q].pc;
   assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based model tracks the expected
// FIFO contents; a negedge monitor compares the DUT head, count and address.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_ready = 1'b0;
   logic [5:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  count;

   logic        rst2 = 1'b1;
   logic [5:0]  imem_addr2;
   logic [31:0] imem_rdata2;
   logic        out_valid2;
   logic [31:0] out_instr2;
   logic [31:0] out_pc2;
   logic [2:0]  count2;

   int          checks = 0;
   int          errors = 0;

   ent_t        mq[$];
   logic [31:0] m_fpc = 32'h0;
   bit          m_cleared = 1'b0;
   bit          mon_en = 1'b0;

   always #5 clk = ~clk;

   // Instruction memory: word k holds A000_0000 + k.
   assign imem_rdata  = 32'hA000_0000 + {26'd0, imem_addr};
   assign imem_rdata2 = 32'hA000_0000 + {26'd0, imem_addr2};

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .count(count)
   );

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_00F8)) dut_wrap (
      .clk(clk), .reset(rst2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .redirect(1'b0), .redirect_pc(32'h0), .out_valid(out_valid2),
      .out_ready(1'b1), .out_instr(out_instr2), .out_pc(out_pc2), .count(count2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      return 32'hA000_0000 + (pc / 4) % 64;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue, updated at each rising edge.
   initial begin
      bit full;
      forever begin
         @(posedge clk);
         if (reset) begin
            mq.delete();
            m_fpc     = 32'h0;
            m_cleared = 1'b1;
            mon_en    = 1'b1;
         end else if (redirect) begin
            mq.delete();
            m_fpc     = redirect_pc & ~32'h3;
            m_cleared = 1'b0;
         end else begin
            full = (mq.size() == DEPTH);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (!full) begin
               mq.push_back('{pc: m_fpc, instr: mem_word(m_fpc)});
               m_fpc     = m_fpc + 32'd4;
               m_cleared = 1'b0;
            end
         end
      end
   end

   // Monitor: compares the presented head and status against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("count", 32'(count), 32'(mq.size()));
            check("out_valid", 32'(out_valid), 32'((mq.size() != 0) && !redirect));
            check("imem_addr", 32'(imem_addr), 32'((m_fpc / 4) % 64));
            if (mq.size() > 0) begin
               check("out_pc", out_pc, mq[0].pc);
               check("out_instr", out_instr, mq[0].instr);
            end else if (m_cleared) begin
               check("out_pc_reset", out_pc, 32'h0);
               check("out_instr_reset", out_instr, 32'h0);
            end
         end
      end
   end

   task automatic step(input bit r, input bit rd, input logic [31:0] rp, input bit rdy);
      @(posedge clk);
      #2;
      reset       = r;
      redirect    = rd;
      redirect_pc = rp;
      out_ready   = rdy;
   endtask

   initial begin
      // Address wrap with RESET_PC = F8 on the second instance.
      @(posedge clk);
      #2;
      rst2 = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k <= 3) check("wrap_addr", 32'(imem_addr2), 32'((8'h3E + k) % 64));
         if (k >= 1) begin
            check("wrap_pc", out_pc2, 32'hF8 + 32'(4 * (k - 1)));
            check("wrap_instr", out_instr2, 32'hA000_0000 + 32'((8'h3E + k - 1) % 64));
            check("wrap_valid", 32'(out_valid2), 32'h1);
         end
      end

      // Streaming with out_ready high.
      step(0, 0, 0, 1);
      repeat (8) step(0, 0, 0, 1);

      // Stall after reset, then release.
      step(1, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0);
      repeat (8) step(0, 0, 0, 1);

      // Single-cycle redirect while streaming.
      step(0, 1, 32'h0000_0043, 1);
      @(negedge clk);
      check("redir_valid", 32'(out_valid), 32'h0);
      repeat (6) step(0, 0, 0, 1);

      // Fill, then reset while full with out_ready low.
      repeat (6) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      @(negedge clk);
      check("rst_full_count", 32'(count), 32'h0);
      check("rst_full_valid", 32'(out_valid), 32'h0);
      check("rst_full_instr", out_instr, 32'h0);
      check("rst_full_pc", out_pc, 32'h0);
      repeat (3) step(0, 0, 0, 1);

      // Redirect and reset together: reset wins.
      step(1, 1, 32'h0000_0080, 1);
      step(0, 0, 0, 1);
      @(negedge clk);
      check("rst_redir_addr", 32'(imem_addr), 32'h0);
      repeat (3) step(0, 0, 0, 1);

      // Redirect held several cycles; last value wins.
      step(0, 1, 32'h0000_0020, 1);
      step(0, 1, 32'h0000_0030, 0);
      step(0, 1, 32'h0000_00FD, 1);
      repeat (4) step(0, 0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(63) == 0), ($urandom_range(15) == 0), $urandom,
              ($urandom_range(3) != 0));
      end
      step(0, 0, 0, 1);
      repeat (4) @(posedge clk);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that drives the read-only instruction memory. It sequences the fetch PC and converts the memory's asynchronous word reads into a registered, in-order instruction stream for decode, with a valid/ready handshake. A small FIFO decouples fetch from downstream stalls. A redirect input from branch resolution flushes the FIFO and restarts fetch at a new PC.

## Interface
- DEPTH, 4: FIFO entries; must be a power of two, minimum 2.
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  6  word address to the instruction memory: fetch_pc[7:2].
- imem_rdata  in  32  combinational read data for imem_addr, valid in the same cycle.
- redirect  in  1  flush the FIFO and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  head entry is available to decode.
- out_ready  in  1  decode accepts the head entry when out_valid is also high.
- out_instr  out  32  instruction word of the head entry.
- out_pc  out  32  byte PC of the head entry.
- count  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- State:
  - fetch_pc, 32-bit register; bits [1:0] are always 0.
  - circular FIFO of {pc, instr} with head/tail pointers and an occupancy counter.
- The FIFO is unregistered toward memory: imem_addr = fetch_pc[7:2], and imem_rdata is sampled at the same edge that captures it.
- push = !redirect && (count != DEPTH).
  - On push: write {fetch_pc, imem_rdata} at tail, advance tail, fetch_pc <= fetch_pc + 4.
- Full FIFO blocks push even if a pop happens in the same cycle; there is no full-bypass.
- pop = out_valid && out_ready; on pop, advance head.
- When push and pop occur in the same cycle, count is unchanged.
- out_valid = (count != 0) && !redirect. This is a combinational path from redirect by design.
- out_instr and out_pc always show the head slot, even when out_valid is 0.
- redirect has priority over everything else:
  - head, tail and count are set to 0;
  - fetch_pc <= {redirect_pc[31:2], 2'b00};
  - no push occurs, and out_ready is ignored.
- Address arithmetic:
  - fetch_pc increments modulo 2^32;
  - imem_addr wraps modulo 64 words (word 63 -> word 0) while fetch_pc keeps counting;
  - out_pc carries the full 32-bit fetch_pc.
- Reset:
  - fetch_pc = RESET_PC with bits [1:0] cleared;
  - FIFO storage, head, tail and count are cleared to 0;
  - out_valid = 0, out_instr = 0, out_pc = 0, count = 0, imem_addr = RESET_PC[7:2].
- Reset overrides redirect.
- Reset asserted mid-stream discards all queued entries on that edge.

## Timing
- Reset deasserted before edge E0: the instruction at RESET_PC is pushed at E0, and out_valid is high after E0.
- Steady state with out_ready held high:
  - one instruction per cycle;
  - count settles at 1;
  - PCs are consecutive (+4).
- Stall with out_ready low:
  - the FIFO fills at one entry per cycle;
  - count reaches DEPTH after DEPTH fill edges;
  - fetch_pc then holds, and imem_addr is stable.
- Release from full:
  - first edge: pop only, count = DEPTH-1;
  - following edges: push and pop together, one instruction per cycle.
- Redirect high at edge E:
  - count = 0 after E;
  - redirect_pc is fetched at E+1;
  - out_valid is high after E+1 with out_pc = redirect_pc.
- Redirect held for several cycles: the FIFO stays empty, and the last redirect_pc value wins.

## Test plan
- Reset, then out_ready=1, with memory word k = 32'hA000_0000+k and RESET_PC=0 -> out_valid rises one edge after reset, and the stream is (pc 0, A0000000), (pc 4, A0000001), (pc 8, A0000002), … with no bubbles.
- out_ready=0 for 6 cycles after reset -> count goes 1,2,3,4,4,4 and imem_addr stops at 4. Then raise out_ready -> pcs 0,4,8,C,10 come out in order with no loss or duplication.
- While streaming, redirect=1 for one cycle with redirect_pc=32'h0000_0043 -> out_valid is 0 in that cycle and count=0 after it. The next accepted entry has pc 32'h40 and instr A0000010.
- RESET_PC=32'hF8 -> imem_addr sequence 3E, 3F, 00, 01, while out_pc reads F8, FC, 100, 104.
- Pulse reset while the FIFO is full and out_ready is low -> count=0, out_valid=0, out_instr=0 and out_pc=0 on the next edge. Fetch restarts at RESET_PC.
- Assert redirect and reset in the same cycle -> the reset values win, and fetch_pc = RESET_PC.
